iterative_multiplier: RTL and testbench
=======================================

# iterative_multiplier

Multi-cycle 64-bit integer multiplier for the LEGv8 datapath, executing MUL, UMULH and SMULH. It consumes the two register-file read buses (BusA, BusB) and the decoded destination register. It returns a 64-bit product half plus a write-enable and register tag to the write-back mux that drives BusW/RW/RegWr. Computation uses a radix-2 shift-add loop: one multiplier bit per cycle, a fixed 64-cycle run phase, and a start/done handshake so control can stall the pipeline.

## Interface
- WIDTH, 64, operand and result width; only 64 is supported.
- Clk  input  1  clock; all state updates on rising edge.
- ResetL  input  1  asynchronous, active-low reset.
- Start  input  1  request; sampled only in IDLE.
- Op  input  2  00 = MUL (low 64 bits), 01 = UMULH (high 64 bits, unsigned), 10 = SMULH (high 64 bits, signed), 11 = reserved, executes as MUL.
- BusA  input  64  multiplicand (Rn), captured when Start is accepted.
- BusB  input  64  multiplier (Rm), captured when Start is accepted.
- RW_in  input  5  destination register, captured with operands.
- Busy  output  1  high whenever state is not IDLE.
- Done  output  1  one-cycle completion pulse.
- Result  output  64  selected product half; held until the next accepted Start.
- RW_out  output  5  captured destination tag.
- RegWr_out  output  1  write request to the register file, pulses with Done.

## Operation
- State machine has three states: IDLE, RUN and DONE.
  - IDLE → RUN when Start = 1. On that edge, capture Op, RW_in, |BusA| → mcand, |BusB| → mplier, and neg = sign(BusA) XOR sign(BusB) (SMULH only; otherwise neg = 0). Also clear the 128-bit accumulator and the 6-bit counter.
  - Magnitude uses two's-complement negation. The magnitude of -2^63 is 2^63, which fits unsigned 64 bits.
  - RUN: each edge, if mplier[0] then acc += mcand << count (128-bit add, no overflow possible). Then mplier >>= 1 and count++. After the edge with count = 63, go to DONE.
  - DONE: on entry, final = neg ? -acc : acc (128-bit negate). Result = final[63:0] for MUL/reserved, final[127:64] for UMULH/SMULH. Done = 1. RegWr_out = 1 unless RW_out == 31. Writes to XZR are suppressed; Done still pulses.
  - DONE → IDLE unconditionally on the next edge.
- Start in RUN or DONE is ignored, with no queuing. Operands and tag are never re-sampled mid-operation.
- MUL low half is sign-independent; no sign correction is applied for Op 00/11.

## Timing
- Reset (ResetL = 0, asynchronous) forces state IDLE and sets all outputs to 0: Busy, Done, RegWr_out, Result, RW_out. Internal acc, mcand, mplier, count and neg are also cleared.
- Reset during RUN or DONE aborts the operation: no Done and no RegWr_out. The first edge after release samples Start normally.
- Start accepted at edge E0:
  - Busy rises after E0.
  - RUN covers edges E1..E64.
  - Done, RegWr_out and the new Result are valid after E64.
  - Done falls and Busy falls after E65.
  - Latency is 64 cycles from acceptance to Done. The earliest next acceptance is E66, i.e. a throughput of one op per 66 cycles.
- Result and RW_out change only on the edge entering DONE. They are stable through the register file's negedge write in the Done cycle and afterwards.
- Done and RegWr_out are exactly one cycle wide and never assert outside DONE.

## Test plan
- Basic MUL: reset, Op = 00, BusA = 3, BusB = 5, RW_in = 7, Start for 1 cycle → Busy high for 65 cycles. Done and RegWr_out high exactly 64 cycles after acceptance. Result = 0x000000000000000F, RW_out = 7.
- UMULH and MUL on all-ones: BusA = BusB = 0xFFFFFFFFFFFFFFFF.
  - UMULH → Result = 0xFFFFFFFFFFFFFFFE.
  - MUL → Result = 0x0000000000000001.
- SMULH signs:
  - -1 × 1 → 0xFFFFFFFFFFFFFFFF.
  - 0x8000000000000000 × 0x8000000000000000 → 0x4000000000000000.
  - 7 × -2 → 0xFFFFFFFFFFFFFFFF.
  - Op = 11 with 7 × -2 → 0xFFFFFFFFFFFFFFF2.
- XZR destination: RW_in = 31, MUL 2 × 2 → Done pulses, RegWr_out stays 0, Result = 4.
- Ignored Start: second Start with different operands at cycles 10 and 64 after acceptance → first result unchanged, only one Done. Start in the Done cycle is also ignored.
- Reset mid-run: assert ResetL = 0 asynchronously 30 cycles into RUN → all outputs read 0 immediately, no Done. After release, a MUL 6 × 7 completes correctly with Result = 42.

Source files
------------

// File: rtl/iterative_multiplier.sv
// Radix-2 shift-add 64x64 multiplier for MUL/UMULH/SMULH with a start/done handshake.
// One multiplier bit per cycle; signed ops work on magnitudes and fix the sign at the end.
`timescale 1ns/1ps
module iterative_multiplier #(
    parameter int WIDTH = 64
) (
    input  logic             Clk,
    input  logic             ResetL,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] BusA,
    input  logic [WIDTH-1:0] BusB,
    input  logic [4:0]       RW_in,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Result,
    output logic [4:0]       RW_out,
    output logic             RegWr_out
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [1:0] OP_UMULH = 2'b01;
    localparam logic [1:0] OP_SMULH = 2'b10;
    localparam logic [4:0] XZR      = 5'd31;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             stateReg, stateNext;
    logic [1:0]         opReg;
    logic [4:0]         rwReg;
    logic [4:0]         rwOutReg;
    logic [WIDTH-1:0]   mcandReg;
    logic [WIDTH-1:0]   mplierReg;
    logic               negReg;
    logic [2*WIDTH-1:0] accReg;
    logic [CW-1:0]      countReg;
    logic [WIDTH-1:0]   resultReg;

    logic               isSigned;
    logic [WIDTH-1:0]   magA;
    logic [WIDTH-1:0]   magB;
    logic [2*WIDTH-1:0] partial;
    logic [2*WIDTH-1:0] accSum;
    logic [2*WIDTH-1:0] finalProd;
    logic               lastIter;
    logic               highHalf;

    // Magnitudes are only taken for SMULH; -2^63 maps to 2^63, still valid as unsigned.
    assign isSigned = (Op == OP_SMULH);
    assign magA     = (isSigned && BusA[WIDTH-1]) ? (~BusA + 1'b1) : BusA;
    assign magB     = (isSigned && BusB[WIDTH-1]) ? (~BusB + 1'b1) : BusB;

    assign partial   = mplierReg[0] ? ({{WIDTH{1'b0}}, mcandReg} << countReg) : '0;
    assign accSum    = accReg + partial;
    assign finalProd = negReg ? (~accSum + 1'b1) : accSum;
    assign lastIter  = (countReg == CW'(WIDTH - 1));
    assign highHalf  = (opReg == OP_UMULH) || (opReg == OP_SMULH);

    always_ff @(posedge Clk or negedge ResetL) begin
        if (!ResetL) begin
            stateReg <= IDLE;
        end else begin
            stateReg <= stateNext;
        end
    end

    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            IDLE:    if (Start) stateNext = RUN;
            RUN:     if (lastIter) stateNext = DONE;
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge ResetL) begin
        if (!ResetL) begin
            opReg     <= '0;
            rwReg     <= '0;
            rwOutReg  <= '0;
            mcandReg  <= '0;
            mplierReg <= '0;
            negReg    <= 1'b0;
            accReg    <= '0;
            countReg  <= '0;
            resultReg <= '0;
        end else begin
            case (stateReg)
                IDLE: begin
                    if (Start) begin
                        opReg     <= Op;
                        rwReg     <= RW_in;
                        mcandReg  <= magA;
                        mplierReg <= magB;
                        negReg    <= isSigned & (BusA[WIDTH-1] ^ BusB[WIDTH-1]);
                        accReg    <= '0;
                        countReg  <= '0;
                    end
                end
                RUN: begin
                    accReg    <= accSum;
                    mplierReg <= mplierReg >> 1;
                    countReg  <= countReg + 1'b1;
                    // Visible outputs only move on the edge that enters DONE.
                    if (lastIter) begin
                        resultReg <= highHalf ? finalProd[2*WIDTH-1:WIDTH] : finalProd[WIDTH-1:0];
                        rwOutReg  <= rwReg;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign Busy      = (stateReg != IDLE);
    assign Done      = (stateReg == DONE);
    assign RegWr_out = (stateReg == DONE) && (rwOutReg != XZR);
    assign Result    = resultReg;
    assign RW_out    = rwOutReg;

endmodule

// File: tb/tb_iterative_multiplier.sv
// Scoreboard bench for iterative_multiplier: directed cases from the plan plus random ops
// checked against a plain 128-bit arithmetic reference.
`timescale 1ns/1ps
module tb_iterative_multiplier;

    logic        Clk = 1'b0;
    logic        ResetL;
    logic        Start;
    logic [1:0]  Op;
    logic [63:0] BusA;
    logic [63:0] BusB;
    logic [4:0]  RW_in;
    logic        Busy;
    logic        Done;
    logic [63:0] Result;
    logic [4:0]  RW_out;
    logic        RegWr_out;

    iterative_multiplier #(.WIDTH(64)) dut (
        .Clk       (Clk),
        .ResetL    (ResetL),
        .Start     (Start),
        .Op        (Op),
        .BusA      (BusA),
        .BusB      (BusB),
        .RW_in     (RW_in),
        .Busy      (Busy),
        .Done      (Done),
        .Result    (Result),
        .RW_out    (RW_out),
        .RegWr_out (RegWr_out)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [63:0] res;
        logic [4:0]  rw;
        logic        wr;
        int          doneCyc;
    } exp_t;

    exp_t sbQ[$];
    int   cyc = 0;
    int   checks = 0;
    int   passes = 0;
    int   issued = 0;
    int   doneCnt = 0;
    logic prevDone = 1'b0;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [63:0] refMul(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b);
        logic signed [127:0] sa, sb, sp;
        logic [127:0] up;
        sa = $signed({{64{a[63]}}, a});
        sb = $signed({{64{b[63]}}, b});
        sp = sa * sb;
        up = {64'd0, a} * {64'd0, b};
        case (op)
            2'b01:   return up[127:64];
            2'b10:   return sp[127:64];
            default: return up[63:0];
        endcase
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // Monitor: pops one expectation per Done pulse.
    always @(negedge Clk) begin
        if (ResetL) begin
            if (RegWr_out) check("regwr_only_with_done", Done, 1);
            if (Done) begin
                check("done_width", prevDone, 0);
                if (sbQ.size() == 0) begin
                    check("done_expected", sbQ.size(), 1);
                end else begin
                    exp_t e;
                    e = sbQ.pop_front();
                    doneCnt++;
                    check("result", Result, e.res);
                    check("rw_out", RW_out, e.rw);
                    check("regwr", RegWr_out, e.wr);
                    check("latency", cyc, e.doneCyc);
                end
            end
            prevDone = Done;
        end else begin
            prevDone = 1'b0;
        end
    end

    task automatic pushExp(input logic [63:0] res, input logic [4:0] rw, input int accept);
        exp_t e;
        e.res = res;
        e.rw = rw;
        e.wr = (rw != 5'd31);
        e.doneCyc = accept + 64;
        sbQ.push_back(e);
        issued++;
    endtask

    task automatic scramble();
        BusA  = rnd64();
        BusB  = rnd64();
        RW_in = 5'($urandom);
        Op    = 2'($urandom);
    endtask

    task automatic doOp(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                        input logic [4:0] rw, input logic [63:0] expRes);
        int busyCnt;
        int accept;
        @(negedge Clk);
        Start = 1'b1; Op = op; BusA = a; BusB = b; RW_in = rw;
        accept = cyc + 1;
        pushExp(expRes, rw, accept);
        @(negedge Clk);
        Start = 1'b0;
        scramble();
        busyCnt = 0;
        for (int i = 0; i < 200 && Busy; i++) begin
            busyCnt++;
            @(negedge Clk);
        end
        check("busy_len", busyCnt, 65);
        $display("op=%0d a=%h b=%h rw=%0d expect=%h busy=%0d", op, a, b, rw, expRes, busyCnt);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", passes, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int accept;
        ResetL = 1'b0; Start = 1'b0; Op = '0; BusA = '0; BusB = '0; RW_in = '0;
        #1;
        check("rst_busy", Busy, 0);
        check("rst_done", Done, 0);
        check("rst_regwr", RegWr_out, 0);
        check("rst_result", Result, 0);
        check("rst_rw_out", RW_out, 0);
        repeat (3) @(negedge Clk);
        ResetL = 1'b1;

        doOp(2'b00, 64'd3, 64'd5, 5'd7, 64'h000000000000000F);
        doOp(2'b01, '1, '1, 5'd3, 64'hFFFFFFFFFFFFFFFE);
        doOp(2'b00, '1, '1, 5'd4, 64'h0000000000000001);
        doOp(2'b10, '1, 64'd1, 5'd5, 64'hFFFFFFFFFFFFFFFF);
        doOp(2'b10, 64'h8000000000000000, 64'h8000000000000000, 5'd6, 64'h4000000000000000);
        doOp(2'b10, 64'd7, -64'sd2, 5'd8, 64'hFFFFFFFFFFFFFFFF);
        doOp(2'b11, 64'd7, -64'sd2, 5'd9, 64'hFFFFFFFFFFFFFFF2);
        doOp(2'b00, 64'd2, 64'd2, 5'd31, 64'd4);

        // Extra Starts at E10, E64 (still RUN) and E65 (DONE) must all be ignored.
        @(negedge Clk);
        Start = 1'b1; Op = 2'b00; BusA = 64'h1234; BusB = 64'h10; RW_in = 5'd9;
        accept = cyc + 1;
        pushExp(64'h12340, 5'd9, accept);
        @(negedge Clk);
        for (int k = 1; k <= 66; k++) begin
            scramble();
            Start = (k == 10 || k == 64 || k == 65);
            @(negedge Clk);
        end
        Start = 1'b0;
        repeat (3) @(negedge Clk);
        check("ignored_busy", Busy, 0);
        check("ignored_hold_result", Result, 64'h12340);
        check("ignored_hold_rw", RW_out, 5'd9);
        $display("ignored-start op: result=%h rw=%0d", Result, RW_out);

        for (int n = 0; n < 20; n++) begin
            logic [1:0]  op;
            logic [63:0] a, b;
            op = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0: begin a = rnd64(); b = rnd64(); end
                1: begin a = 64'($urandom_range(0, 1000)); b = -64'($urandom_range(0, 1000)); end
                2: begin a = 64'h8000000000000000; b = rnd64(); end
                default: begin a = '1; b = rnd64(); end
            endcase
            doOp(op, a, b, 5'($urandom_range(0, 31)), refMul(op, a, b));
        end

        // Asynchronous reset 30 cycles into RUN aborts the op.
        @(negedge Clk);
        Start = 1'b1; Op = 2'b00; BusA = 64'd100; BusB = 64'd200; RW_in = 5'd5;
        accept = cyc + 1;
        @(negedge Clk);
        Start = 1'b0;
        while (cyc < accept + 30) @(negedge Clk);
        #2 ResetL = 1'b0;
        #1;
        check("abort_busy", Busy, 0);
        check("abort_done", Done, 0);
        check("abort_regwr", RegWr_out, 0);
        check("abort_result", Result, 0);
        check("abort_rw_out", RW_out, 0);
        $display("reset mid-run: busy=%0d done=%0d result=%h", Busy, Done, Result);
        repeat (2) @(negedge Clk);
        ResetL = 1'b1;
        doOp(2'b00, 64'd6, 64'd7, 5'd10, 64'd42);

        repeat (5) @(negedge Clk);
        check("sb_drained", sbQ.size(), 0);
        check("done_count", doneCnt, issued);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
